// File: rtl/conv3x3_stream.sv
// Streaming 3x3 signed-kernel convolution with line buffers, valid/ready flow control and
// frame-synchronous kernel double-buffering. Define CONV3X3_ABS_EN for magnitude rectification.
module conv3x3_stream #(
    parameter int unsigned W      = 5,
    parameter int unsigned H      = 5,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned COEF_W = 8,
    parameter int unsigned SHIFT  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        pixel_in,
    input  logic                     pixel_valid,
    input  logic                     pixel_sof,
    output logic                     pixel_ready,
    input  logic                     coef_we,
    input  logic [3:0]               coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic [DATA_W-1:0]        pixel_out,
    output logic                     pixel_out_valid,
    input  logic                     pixel_out_ready,
    output logic                     pixel_out_eof
);

    localparam int unsigned ACC_W = DATA_W + COEF_W + 5;
    localparam int unsigned CW    = $clog2(W);
    localparam int unsigned RW    = $clog2(H);
    localparam int unsigned TAPS  = 9;
    localparam logic signed [ACC_W-1:0]  PIX_MAX  = ACC_W'((1 << DATA_W) - 1);
    localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(1 << SHIFT);

    logic                     adv;
    logic                     accept;
    logic                     at_origin;
    logic [CW-1:0]            col;
    logic [CW-1:0]            pos_col;
    logic [RW-1:0]            row;
    logic [RW-1:0]            pos_row;
    logic [DATA_W-1:0]        lb1 [W];
    logic [DATA_W-1:0]        lb2 [W];
    logic [DATA_W-1:0]        win [TAPS];
    logic                     w_valid;
    logic                     w_eof;
    logic                     s1_valid;
    logic                     s1_eof;
    logic signed [COEF_W-1:0] shadow [TAPS];
    logic signed [COEF_W-1:0] active [TAPS];
    logic signed [ACC_W-1:0]  acc_c;
    logic signed [ACC_W-1:0]  s1_acc;
    logic signed [ACC_W-1:0]  res_c;
    logic signed [ACC_W-1:0]  mag_c;
    logic [DATA_W-1:0]        sat_c;

    // Whole pipeline moves in lockstep whenever the output register can be refilled.
    assign adv         = !pixel_out_valid || pixel_out_ready;
    assign pixel_ready = adv;
    assign accept      = pixel_valid && adv;
    assign pos_col     = pixel_sof ? '0 : col;
    assign pos_row     = pixel_sof ? '0 : row;
    assign at_origin   = (pos_col == '0) && (pos_row == '0);

    // Raster position, line buffers and the 3x3 window (k = 3*row + col, row 0 oldest).
    always_ff @(posedge clk) begin
        if (rst) begin
            col     <= '0;
            row     <= '0;
            w_valid <= 1'b0;
            w_eof   <= 1'b0;
            for (int unsigned k = 0; k < W; k++) begin
                lb1[k] <= '0;
                lb2[k] <= '0;
            end
            for (int unsigned k = 0; k < TAPS; k++) begin
                win[k] <= '0;
            end
        end else if (adv) begin
            w_valid <= accept && (pos_row >= RW'(2)) && (pos_col >= CW'(2));
            w_eof   <= accept && (pos_row == RW'(H - 1)) && (pos_col == CW'(W - 1));
            if (accept) begin
                if (pos_col == CW'(W - 1)) begin
                    col <= '0;
                    row <= (pos_row == RW'(H - 1)) ? '0 : pos_row + RW'(1);
                end else begin
                    col <= pos_col + CW'(1);
                    row <= pos_row;
                end
                win[0]       <= win[1];
                win[1]       <= win[2];
                win[2]       <= lb2[pos_col];
                win[3]       <= win[4];
                win[4]       <= win[5];
                win[5]       <= lb1[pos_col];
                win[6]       <= win[7];
                win[7]       <= win[8];
                win[8]       <= pixel_in;
                lb2[pos_col] <= lb1[pos_col];
                lb1[pos_col] <= pixel_in;
            end
        end
    end

    // Shadow bank takes writes at once; active bank swaps in at the first pixel of a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < TAPS; k++) begin
                shadow[k] <= (k == 4) ? COEF_ONE : '0;
                active[k] <= (k == 4) ? COEF_ONE : '0;
            end
        end else begin
            for (int unsigned k = 0; k < TAPS; k++) begin
                if (coef_we && (coef_addr == 4'(k))) begin
                    shadow[k] <= coef_data;
                end
                if (accept && at_origin) begin
                    active[k] <= (coef_we && (coef_addr == 4'(k))) ? coef_data : shadow[k];
                end
            end
        end
    end

    always_comb begin
        acc_c = '0;
        for (int unsigned k = 0; k < TAPS; k++) begin
            acc_c = acc_c + $signed(ACC_W'(win[k])) * ACC_W'(active[k]);
        end
    end

    always_comb begin
        res_c = s1_acc >>> SHIFT;
`ifdef CONV3X3_ABS_EN
        mag_c = res_c[ACC_W-1] ? -res_c : res_c;
`else
        mag_c = res_c[ACC_W-1] ? '0 : res_c;
`endif
        sat_c = (mag_c > PIX_MAX) ? {DATA_W{1'b1}} : mag_c[DATA_W-1:0];
    end

    // S1: multiply-accumulate; S2: shift, rectify, saturate.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid        <= 1'b0;
            s1_eof          <= 1'b0;
            s1_acc          <= '0;
            pixel_out_valid <= 1'b0;
            pixel_out_eof   <= 1'b0;
            pixel_out       <= '0;
        end else if (adv) begin
            s1_valid        <= w_valid;
            s1_eof          <= w_eof;
            s1_acc          <= acc_c;
            pixel_out_valid <= s1_valid;
            pixel_out_eof   <= s1_valid && s1_eof;
            if (s1_valid) begin
                pixel_out <= sat_c;
            end
        end
    end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Self-checking bench for conv3x3_stream against a direct 2-D convolution model.
module tb_conv3x3_stream;

    localparam int W   = 5;
    localparam int H   = 5;
    localparam int DW  = 8;
    localparam int CWD = 8;
    localparam int SH  = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [DW-1:0]         pixel_in = '0;
    logic                  pixel_valid = 1'b0;
    logic                  pixel_sof = 1'b0;
    logic                  pixel_ready;
    logic                  coef_we = 1'b0;
    logic [3:0]            coef_addr = '0;
    logic signed [CWD-1:0] coef_data = '0;
    logic [DW-1:0]         pixel_out;
    logic                  pixel_out_valid;
    logic                  pixel_out_ready = 1'b1;
    logic                  pixel_out_eof;

    conv3x3_stream #(.W(W), .H(H), .DATA_W(DW), .COEF_W(CWD), .SHIFT(SH)) dut (
        .clk(clk), .rst(rst), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
        .pixel_sof(pixel_sof), .pixel_ready(pixel_ready), .coef_we(coef_we),
        .coef_addr(coef_addr), .coef_data(coef_data), .pixel_out(pixel_out),
        .pixel_out_valid(pixel_out_valid), .pixel_out_ready(pixel_out_ready),
        .pixel_out_eof(pixel_out_eof)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int frame [H][W];
    int kern  [9];
    int exp_pix[$], exp_eof[$];
    int obs_pix[$], obs_eof[$], obs_cyc[$];
    int acc_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Record every output handshake that will happen at the coming rising edge.
    always @(negedge clk) begin
        #1;
        if (!rst && pixel_out_valid && pixel_out_ready) begin
            obs_pix.push_back(int'(pixel_out));
            obs_eof.push_back(int'(pixel_out_eof));
            obs_cyc.push_back(cyc);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic clear_all();
        exp_pix.delete(); exp_eof.delete();
        obs_pix.delete(); obs_eof.delete(); obs_cyc.delete();
        acc_cyc.delete();
    endtask

    // Reference: every full 3x3 neighbourhood, raster order, using the current kern/frame.
    task automatic model_frame();
        for (int r = 2; r < H; r++) begin
            for (int c = 2; c < W; c++) begin
                int acc = 0;
                int res;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        acc += frame[r-2+i][c-2+j] * kern[3*i+j];
                res = acc >>> SH;
`ifdef CONV3X3_ABS_EN
                if (res < 0) res = -res;
`else
                if (res < 0) res = 0;
`endif
                if (res > 255) res = 255;
                exp_pix.push_back(res);
                exp_eof.push_back((r == H-1 && c == W-1) ? 1 : 0);
            end
        end
    endtask

    task automatic set_ring();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                frame[r][c] = (r == 0 || c == 0 || r == H-1 || c == W-1) ? 10 :
                              (r == 2 && c == 2) ? 100 : 50;
    endtask

    task automatic set_random_frame();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                frame[r][c] = int'($urandom_range(255));
    endtask

    task automatic set_kern_identity();
        for (int k = 0; k < 9; k++) kern[k] = (k == 4) ? 16 : 0;
    endtask

    task automatic load_kernel();
        for (int k = 0; k < 9; k++) begin
            coef_we = 1'b1; coef_addr = 4'(k); coef_data = CWD'(kern[k]);
            @(negedge clk);
        end
        coef_we = 1'b0;
    endtask

    task automatic send_pixel(input int v, input bit sof);
        int n = 0;
        pixel_in = DW'(v); pixel_sof = sof; pixel_valid = 1'b1;
        #1;
        while (!pixel_ready && n < 200) begin
            @(negedge clk); #1; n++;
        end
        acc_cyc.push_back(cyc + 1);
        @(negedge clk);
        pixel_valid = 1'b0; pixel_sof = 1'b0;
    endtask

    task automatic stream_frame(input int start, input int gap_pct);
        for (int p = start; p < W*H; p++) begin
            send_pixel(frame[p / W][p % W], p == 0);
            if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct)
                repeat ($urandom_range(1, 3)) @(negedge clk);
        end
    endtask

    task automatic wait_drain(input int n);
        int t = 0;
        while (obs_pix.size() < n && t < 300) begin
            @(negedge clk); t++;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (pixel_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", pixel_out_valid); end
        n_checks++; if (pixel_out !== '0) begin n_fail++; $display("FAIL reset_pixel: got %0d want 0", pixel_out); end
        n_checks++; if (pixel_out_eof !== 1'b0) begin n_fail++; $display("FAIL reset_eof: got %b want 0", pixel_out_eof); end
        n_checks++; if (pixel_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", pixel_ready); end
        @(negedge clk);
    endtask

    task automatic test_identity_ring();
        clear_all(); set_ring(); set_kern_identity(); model_frame();
        stream_frame(0, 0);
        wait_drain(exp_pix.size());
        n_checks++; if (obs_pix.size() != exp_pix.size()) begin n_fail++; $display("FAIL ident_count: got %0d want %0d", obs_pix.size(), exp_pix.size()); end
        for (int i = 0; i < exp_pix.size() && i < obs_pix.size(); i++) begin
            n_checks++;
            if (obs_pix[i] !== exp_pix[i] || obs_eof[i] !== exp_eof[i]) begin
                n_fail++; $display("FAIL ident_out[%0d]: got %0d eof %0d want %0d eof %0d", i, obs_pix[i], obs_eof[i], exp_pix[i], exp_eof[i]);
            end
        end
        if (obs_cyc.size() > 0 && acc_cyc.size() > 12) begin
            n_checks++;
            if (obs_cyc[0] - acc_cyc[12] != 2) begin n_fail++; $display("FAIL ident_latency: got %0d want 2", obs_cyc[0] - acc_cyc[12]); end
        end else begin
            n_checks++; n_fail++; $display("FAIL ident_latency: got no output want 2");
        end
    endtask

    task automatic test_kernels();
        int spec_idx [4] = '{4, 0, 0, 0};
        int spec_val [4];
        spec_val[0] = 31; spec_val[1] = 9; spec_val[3] = 255;
`ifdef CONV3X3_ABS_EN
        spec_val[2] = 50;
`else
        spec_val[2] = 0;
`endif
        for (int t = 0; t < 4; t++) begin
            clear_all();
            for (int k = 0; k < 9; k++)
                case (t)
                    0: kern[k] = 1;
                    1: kern[k] = (k == 4) ? 8 : -1;
                    2: kern[k] = (k == 4) ? -16 : 0;
                    default: kern[k] = 127;
                endcase
            set_ring();
            if (t == 3)
                for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) frame[r][c] = 255;
            model_frame();
            load_kernel();
            stream_frame(0, 0);
            wait_drain(exp_pix.size());
            n_checks++; if (obs_pix.size() != exp_pix.size()) begin n_fail++; $display("FAIL kern%0d_count: got %0d want %0d", t, obs_pix.size(), exp_pix.size()); end
            for (int i = 0; i < exp_pix.size() && i < obs_pix.size(); i++) begin
                n_checks++;
                if (obs_pix[i] !== exp_pix[i] || obs_eof[i] !== exp_eof[i]) begin
                    n_fail++; $display("FAIL kern%0d_out[%0d]: got %0d eof %0d want %0d eof %0d", t, i, obs_pix[i], obs_eof[i], exp_pix[i], exp_eof[i]);
                end
            end
            if (obs_pix.size() > spec_idx[t]) begin
                n_checks++;
                if (obs_pix[spec_idx[t]] !== spec_val[t]) begin n_fail++; $display("FAIL kern%0d_known: got %0d want %0d", t, obs_pix[spec_idx[t]], spec_val[t]); end
            end
        end
    endtask

    task automatic test_back_pressure();
        clear_all(); set_ring(); set_kern_identity(); model_frame();
        load_kernel();
        fork
            stream_frame(0, 0);
            begin
                int t = 0;
                logic [DW-1:0] held;
                @(negedge clk);
                while (!(pixel_out_valid && obs_pix.size() >= 4) && t < 100) begin
                    @(negedge clk); t++;
                end
                pixel_out_ready = 1'b0;
                held = pixel_out;
                for (int s = 0; s < 3; s++) begin
                    #1;
                    n_checks++; if (pixel_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready[%0d]: got %b want 0", s, pixel_ready); end
                    n_checks++; if (pixel_out_valid !== 1'b1 || pixel_out !== held) begin
                        n_fail++; $display("FAIL stall_hold[%0d]: got %0d valid %b want %0d valid 1", s, pixel_out, pixel_out_valid, held);
                    end
                    @(negedge clk);
                end
                pixel_out_ready = 1'b1;
            end
        join
        wait_drain(exp_pix.size());
        n_checks++; if (obs_pix.size() != exp_pix.size()) begin n_fail++; $display("FAIL bp_count: got %0d want %0d", obs_pix.size(), exp_pix.size()); end
        for (int i = 0; i < exp_pix.size() && i < obs_pix.size(); i++) begin
            n_checks++;
            if (obs_pix[i] !== exp_pix[i] || obs_eof[i] !== exp_eof[i]) begin
                n_fail++; $display("FAIL bp_out[%0d]: got %0d eof %0d want %0d eof %0d", i, obs_pix[i], obs_eof[i], exp_pix[i], exp_eof[i]);
            end
        end
    endtask

    task automatic test_double_buffer();
        clear_all(); set_ring(); set_kern_identity(); model_frame();
        load_kernel();
        fork
            stream_frame(0, 0);
            begin
                int t = 0;
                while (acc_cyc.size() < 10 && t < 100) begin @(negedge clk); t++; end
                for (int k = 0; k < 8; k++) kern[k] = 1;
                for (int k = 0; k < 8; k++) begin
                    coef_we = 1'b1; coef_addr = 4'(k); coef_data = 8'sd1;
                    @(negedge clk);
                end
                coef_we = 1'b0;
            end
        join
        // Last tap lands on the same cycle as the next frame's first pixel.
        for (int k = 0; k < 9; k++) kern[k] = 1;
        set_random_frame(); model_frame();
        coef_we = 1'b1; coef_addr = 4'd8; coef_data = 8'sd1;
        send_pixel(frame[0][0], 1'b1);
        coef_we = 1'b0;
        stream_frame(1, 0);
        wait_drain(exp_pix.size());
        n_checks++; if (obs_pix.size() != exp_pix.size()) begin n_fail++; $display("FAIL dbuf_count: got %0d want %0d", obs_pix.size(), exp_pix.size()); end
        for (int i = 0; i < exp_pix.size() && i < obs_pix.size(); i++) begin
            n_checks++;
            if (obs_pix[i] !== exp_pix[i] || obs_eof[i] !== exp_eof[i]) begin
                n_fail++; $display("FAIL dbuf_out[%0d]: got %0d eof %0d want %0d eof %0d", i, obs_pix[i], obs_eof[i], exp_pix[i], exp_eof[i]);
            end
        end
    endtask

    task automatic test_disruption();
        clear_all(); set_random_frame();
        for (int p = 0; p < 12; p++) send_pixel(frame[p / W][p % W], p == 0);
        rst = 1'b1;
        @(negedge clk); #1;
        n_checks++; if (pixel_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b want 0", pixel_out_valid); end
        @(negedge clk);
        rst = 1'b0;
        clear_all(); set_random_frame(); set_kern_identity(); model_frame();
        stream_frame(0, 0);
        // Abandoned partial frame followed by a fresh frame marked with sof.
        for (int p = 0; p < 8; p++) send_pixel(int'($urandom_range(255)), p == 0);
        set_random_frame(); model_frame();
        stream_frame(0, 0);
        wait_drain(exp_pix.size());
        n_checks++; if (obs_pix.size() != exp_pix.size()) begin n_fail++; $display("FAIL disrupt_count: got %0d want %0d", obs_pix.size(), exp_pix.size()); end
        for (int i = 0; i < exp_pix.size() && i < obs_pix.size(); i++) begin
            n_checks++;
            if (obs_pix[i] !== exp_pix[i] || obs_eof[i] !== exp_eof[i]) begin
                n_fail++; $display("FAIL disrupt_out[%0d]: got %0d eof %0d want %0d eof %0d", i, obs_pix[i], obs_eof[i], exp_pix[i], exp_eof[i]);
            end
        end
    endtask

    task automatic test_random();
        bit done = 1'b0;
        clear_all();
        fork
            begin
                for (int f = 0; f < 4; f++) begin
                    for (int k = 0; k < 9; k++) kern[k] = int'($urandom_range(60)) - 20;
                    set_random_frame(); model_frame();
                    load_kernel();
                    stream_frame(0, 30);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    pixel_out_ready = ($urandom_range(3) != 0);
                end
                pixel_out_ready = 1'b1;
            end
        join
        wait_drain(exp_pix.size());
        n_checks++; if (obs_pix.size() != exp_pix.size()) begin n_fail++; $display("FAIL rand_count: got %0d want %0d", obs_pix.size(), exp_pix.size()); end
        for (int i = 0; i < exp_pix.size() && i < obs_pix.size(); i++) begin
            n_checks++;
            if (obs_pix[i] !== exp_pix[i] || obs_eof[i] !== exp_eof[i]) begin
                n_fail++; $display("FAIL rand_out[%0d]: got %0d eof %0d want %0d eof %0d", i, obs_pix[i], obs_eof[i], exp_pix[i], exp_eof[i]);
            end
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_identity_ring();
        test_kernels();
        test_back_pressure();
        test_double_buffer();
        test_disruption();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv3x3_stream.md
# conv3x3_stream

Parametrised streaming 3×3 convolution engine, the next-generation pixel core for `cnn_top`. It accepts a raster-order pixel stream of a W×H frame and maintains two line buffers plus a 3×3 window. It produces one filtered pixel per valid window ((W−2)×(H−2) per frame) using a runtime-loadable signed kernel. Both sides use valid/ready back-pressure, and kernel updates are double-buffered at frame boundaries.

## Interface
- `W`, 5, frame width in pixels (≥3)
- `H`, 5, frame height in lines (≥3)
- `DATA_W`, 8, unsigned pixel width
- `COEF_W`, 8, signed coefficient width
- `SHIFT`, 4, arithmetic right shift applied to the accumulator
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `pixel_in`  in  DATA_W  input pixel
- `pixel_valid`  in  1  input pixel present
- `pixel_sof`  in  1  marks the first pixel of a frame (qualified by accept)
- `pixel_ready`  out  1  engine can accept `pixel_in` this cycle
- `coef_we`  in  1  write strobe for the shadow kernel
- `coef_addr`  in  4  kernel index 0..8; 9..15 are ignored
- `coef_data`  in  COEF_W  signed coefficient
- `pixel_out`  out  DATA_W  filtered pixel
- `pixel_out_valid`  out  1  `pixel_out` valid
- `pixel_out_ready`  in  1  downstream accepts `pixel_out`
- `pixel_out_eof`  out  1  qualifies the last output pixel of a frame

## Operation
- **Accept:** a pixel is accepted when `pixel_valid && pixel_ready`.
- **Position tracking:** on each accept, the col counter (0..W−1) and row counter (0..H−1) advance in raster order. Both wrap to 0 after (H−1, W−1).
- **Frame resync:** an accept with `pixel_sof=1` forces the position to (0,0) for that pixel, whatever the counter state.
- **Line buffers:** two W-deep buffers hold rows r−1 and r−2. The 3×3 window shifts left by one column on every accept.
- **Window emit:** a window is emitted when the accepted pixel is at r≥2, c≥2.
  - Kernel index k = 3·i + j, where i=0 is row r−2 and j=0 is column c−2.
- **Arithmetic:**
  - acc = Σ pixel·coef, signed, ACC_W = DATA_W + COEF_W + 5.
  - res = acc >>> SHIFT.
  - If res < 0, the rectify rule applies (see Configuration).
  - The value is then saturated to 2^DATA_W − 1.
- **Kernel banks:**
  - `coef_we` writes the shadow bank immediately.
  - The shadow bank is copied to the active bank on the cycle a pixel is accepted at position (0,0), including via `pixel_sof`.
  - A frame in progress always uses one consistent kernel.
- **Reset state:**
  - Active and shadow coefficients: index 4 = 1<<SHIFT, all others 0 (identity).
  - Counters 0, line buffers and window 0, pipeline empty.
  - `pixel_out_valid`=0, `pixel_out`=0, `pixel_out_eof`=0, `pixel_ready`=1 from the first cycle after reset.
- **Reset mid-frame:** all in-flight outputs are discarded and the next accepted pixel is treated as (0,0).
- **`pixel_out_eof`:** asserted with the output produced from the window at (H−1, W−1).

## Timing
- **Pipeline:** two stages.
  - S1 registers the 9 products and their sum.
  - S2 registers shift, rectify and saturate into `pixel_out`.
- **Latency:** a pixel accepted at edge t that completes a window gives `pixel_out_valid`=1 after edge t+2, provided there is no stall.
- **Global advance:** `adv = !pixel_out_valid || pixel_out_ready`.
  - `pixel_ready = adv`, which is combinational from `pixel_out_ready` and the output register.
  - Line buffers, counters, window and S1/S2 update only when `adv`=1.
- **Stall:** while `pixel_out_valid && !pixel_out_ready`, `pixel_out`, `pixel_out_valid` and `pixel_out_eof` hold stable, and no input is taken.
- **Throughput:** one pixel in per cycle and one output per cycle when `pixel_out_ready`=1 continuously.
- **Bubbles:** `pixel_valid`=0 cycles insert bubbles. Bubbles propagate through S1/S2 and drop `pixel_out_valid` with no data loss.
- **Simultaneous events:**
  - When `coef_we` coincides with the (0,0) accept, the new write is included in the copy (write-then-copy).
  - `pixel_sof` asserted on an already-(0,0) pixel has no additional effect.

## Configuration
- Macro: `CONV3X3_ABS_EN`.
- **Defined:** a negative res becomes |res| (edge-magnitude mode), then saturates.
- **Undefined:** a negative res clamps to 0 (ReLU), then saturates.
- Everything else is identical in both builds.

## Test plan
- **Identity kernel, ring frame:** reset, W=H=5, frame rows 10,10,10,10,10 / 10,50,50,50,10 / 10,50,100,50,10 / 10,50,50,50,10 / 10,10,10,10,10, streamed back-to-back.
  - Exactly 9 outputs: 50,50,50,50,100,50,50,50,50.
  - `pixel_out_eof` only on the 9th output.
  - First output 2 cycles after accepting the pixel at (2,2).
- **All-ones kernel, same frame:** centre window gives 500>>4 = 31. Laplacian (centre 8, others −1): top-left window gives 150>>4 = 9.
- **Negative result:** kernel with index 4 = −16, others 0.
  - Top-left output is 50 when built with `CONV3X3_ABS_EN`.
  - Top-left output is 0 without it.
- **Saturation:** all coefficients 127, all pixels 255 (acc 291465 → res 18216) → every output is 255.
- **Back-pressure:** drop `pixel_out_ready` for 3 cycles mid-frame.
  - `pixel_ready`=0 while `pixel_out_valid`=1.
  - `pixel_out` stays stable.
  - Output sequence identical to the unstalled run.
- **Kernel double-buffering:** write the all-ones kernel while frame 1 (identity) is mid-stream. Frame 1 outputs stay identity; frame 2 outputs reflect all-ones.
- **Mid-frame disruption:** assert `rst` after 12 pixels → `pixel_out_valid`=0 next cycle and the next frame's output is correct. A `pixel_sof` pulse mid-frame likewise restarts the position at (0,0).
